// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the uart_tx arbiter.
// The UART_ARB_LOCK_EN macro (see uart_tx_arbiter.sv) does not affect this package.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_e;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  // Index width for N requesters, never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width: must hold BUSY_TIMEOUT-1.
  function automatic int cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  function automatic bit n_req_ok(input int n);
    return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first valid index after ptr, scanning modulo N_REQ.
// Pure combinational; UART_ARB_LOCK_EN has no effect here.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]          valid,
  input  logic [grant_w(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]          grant,
  output logic [grant_w(N_REQ)-1:0] idx,
  output logic                      any
);

  localparam int GRANT_W = grant_w(N_REQ);

  logic [GRANT_W-1:0] cand;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GRANT_W'((int'(ptr) + i) % N_REQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers, with a start watchdog.
// Optional packet lock (hold the grant until req_last) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [8*N_REQ-1:0]        req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  output logic [grant_w(N_REQ)-1:0] grant_id,
  output logic                      timeout_err
);

  localparam int GRANT_W = grant_w(N_REQ);
  localparam int CNT_W   = cnt_w(BUSY_TIMEOUT);

  if (!n_req_ok(N_REQ) || BUSY_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..8 and BUSY_TIMEOUT must be >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_start_d, timeout_d;
  logic [7:0]         tx_data_d;
  logic [GRANT_W-1:0] grant_d;

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   pick_grant;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;
  logic [7:0]         req_bytes [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign req_bytes[k] = req_data[8*k +: 8];
  end

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .valid(eligible),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic               lock_q;
  logic [GRANT_W-1:0] lock_id_q;

  // While a packet is open only its owner may win, regardless of ptr.
  always_comb begin
    eligible = req_valid;
    if (lock_q) eligible = req_valid & (N_REQ'(1) << lock_id_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (|req_ready) begin
      lock_q    <= !req_last[pick_idx];
      lock_id_q <= pick_idx;
    end else if (timeout_d) begin
      lock_q    <= 1'b0;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_start_d = tx_start;
    tx_data_d  = tx_data;
    grant_d    = grant_id;
    timeout_d  = 1'b0;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (!rst && !tx_busy && pick_any) begin
          req_ready  = pick_grant;
          tx_data_d  = req_bytes[pick_idx];
          grant_d    = pick_idx;
          ptr_d      = pick_idx;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = S_DRAIN;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and free the channel.
          tx_start_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= GRANT_W'(N_REQ - 1);
      cnt_q       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_d;
      timeout_err <= timeout_d;
    end
  end

endmodule
